// File: rtl/actuadores_pkg.sv
// Shared encodings for the actuator output stage: fan/alarm state codes and
// the layout of the 4-bit activity word shown on the 7-segment digit.
package actuadores_pkg;

   typedef enum logic [1:0] {
      F_OFF  = 2'b00,
      F_ON   = 2'b01,
      F_HOLD = 2'b10
   } fan_state_t;

   typedef enum logic [1:0] {
      A_IDLE     = 2'b00,
      A_BEEP_ON  = 2'b01,
      A_BEEP_OFF = 2'b10,
      A_SILENCIO = 2'b11
   } alarm_state_t;

   localparam int EST_FIELD_W = 2;
   localparam int EST_FAN_LSB = 2;
   localparam int EST_ALM_LSB = 0;

   function automatic logic [3:0] pack_estado(input fan_state_t f, input alarm_state_t a);
      logic [3:0] e;
      e = '0;
      e[EST_FAN_LSB +: EST_FIELD_W] = f;
      e[EST_ALM_LSB +: EST_FIELD_W] = a;
      return e;
   endfunction

endpackage

// File: rtl/gen_tick.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV clocks,
// on the last count of each period.
module gen_tick #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
      tick  = (pre_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

endmodule

// File: rtl/control_actuadores.sv
// Actuator drive stage: fan with minimum on-time and run-on, pulsed buzzer with
// operator silence, steady alarm lamp, and a status word for the display.
module control_actuadores
   import actuadores_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned FAN_MIN_ON  = 2000,
   parameter int unsigned FAN_OFF_DLY = 1000,
   parameter int unsigned BEEP_ON     = 250,
   parameter int unsigned BEEP_OFF    = 250,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Ventilacion,
   input  logic       Alarma,
   input  logic       Silenciar,
   output logic       Ventilador,
   output logic       Zumbador,
   output logic       Led_Alarma,
   output logic [3:0] Estado_Act
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LD_MIN_ON = CNT_W'(FAN_MIN_ON);
   localparam logic [CNT_W-1:0] LD_OFFDLY = CNT_W'(FAN_OFF_DLY);
   localparam logic [CNT_W-1:0] LD_B_ON   = CNT_W'(BEEP_ON);
   localparam logic [CNT_W-1:0] LD_B_OFF  = CNT_W'(BEEP_OFF);

   logic tick;

   gen_tick #(.TICK_DIV(TICK_DIV)) u_gen_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   fan_state_t       fan_q, fan_d;
   alarm_state_t     alm_q, alm_d;
   logic [CNT_W-1:0] fan_cnt_q, fan_cnt_d;
   logic [CNT_W-1:0] alm_cnt_q, alm_cnt_d;
   logic             ventilador_q, ventilador_d;
   logic             zumbador_q, zumbador_d;
   logic             led_q, led_d;
   logic [3:0]       estado_q, estado_d;

   // Fan: once min-on has run out the counter parks at 0 until the request drops.
   always_comb begin
      fan_d     = fan_q;
      fan_cnt_d = fan_cnt_q;
      case (fan_q)
         F_OFF: begin
            if (Ventilacion) begin
               fan_d     = F_ON;
               fan_cnt_d = LD_MIN_ON;
            end
         end
         F_ON: begin
            if (fan_cnt_q == '0) begin
               if (!Ventilacion) begin
                  fan_d     = F_HOLD;
                  fan_cnt_d = LD_OFFDLY;
               end
            end else if (tick) begin
               fan_cnt_d = fan_cnt_q - CNT_ONE;
            end
         end
         F_HOLD: begin
            if (Ventilacion) begin
               fan_d     = F_ON;
               fan_cnt_d = LD_MIN_ON;
            end else if (tick) begin
               if (fan_cnt_q == CNT_ONE) begin
                  fan_d     = F_OFF;
                  fan_cnt_d = '0;
               end else begin
                  fan_cnt_d = fan_cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            fan_d     = F_OFF;
            fan_cnt_d = '0;
         end
      endcase
   end

   // Alarm: a dropped request wins over everything, including a same-cycle silence.
   always_comb begin
      alm_d     = alm_q;
      alm_cnt_d = alm_cnt_q;
      if (!Alarma) begin
         alm_d     = A_IDLE;
         alm_cnt_d = '0;
      end else begin
         case (alm_q)
            A_IDLE: begin
               alm_d     = A_BEEP_ON;
               alm_cnt_d = LD_B_ON;
            end
            A_BEEP_ON, A_BEEP_OFF: begin
               if (Silenciar) begin
                  alm_d     = A_SILENCIO;
                  alm_cnt_d = '0;
               end else if (tick) begin
                  if (alm_cnt_q == CNT_ONE) begin
                     alm_d     = (alm_q == A_BEEP_ON) ? A_BEEP_OFF : A_BEEP_ON;
                     alm_cnt_d = (alm_q == A_BEEP_ON) ? LD_B_OFF : LD_B_ON;
                  end else begin
                     alm_cnt_d = alm_cnt_q - CNT_ONE;
                  end
               end
            end
            A_SILENCIO: alm_cnt_d = '0;
            default: begin
               alm_d     = A_IDLE;
               alm_cnt_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      ventilador_d = (fan_d != F_OFF);
      zumbador_d   = (alm_d == A_BEEP_ON);
      led_d        = (alm_d != A_IDLE);
      estado_d     = pack_estado(fan_d, alm_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fan_q        <= F_OFF;
         alm_q        <= A_IDLE;
         fan_cnt_q    <= '0;
         alm_cnt_q    <= '0;
         ventilador_q <= 1'b0;
         zumbador_q   <= 1'b0;
         led_q        <= 1'b0;
         estado_q     <= '0;
      end else begin
         fan_q        <= fan_d;
         alm_q        <= alm_d;
         fan_cnt_q    <= fan_cnt_d;
         alm_cnt_q    <= alm_cnt_d;
         ventilador_q <= ventilador_d;
         zumbador_q   <= zumbador_d;
         led_q        <= led_d;
         estado_q     <= estado_d;
      end
   end

   assign Ventilador = ventilador_q;
   assign Zumbador   = zumbador_q;
   assign Led_Alarma = led_q;
   assign Estado_Act = estado_q;

endmodule

// File: tb/tb_control_actuadores.sv
// Bench for control_actuadores: fixed vector table, directed timing sequences
// and a random run, all checked against a deadline-based reference model.
module tb_control_actuadores;

   localparam int TICK_DIV    = 4;
   localparam int FAN_MIN_ON  = 3;
   localparam int FAN_OFF_DLY = 2;
   localparam int BEEP_ON     = 2;
   localparam int BEEP_OFF    = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ventilacion = 1'b0;
   logic       alarma = 1'b0;
   logic       silenciar = 1'b0;
   logic       ventilador, zumbador, led_alarma;
   logic [3:0] estado_act;

   int n_checks = 0;
   int n_err = 0;

   control_actuadores #(
      .TICK_DIV(TICK_DIV), .FAN_MIN_ON(FAN_MIN_ON), .FAN_OFF_DLY(FAN_OFF_DLY),
      .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .Ventilacion(ventilacion), .Alarma(alarma),
      .Silenciar(silenciar), .Ventilador(ventilador), .Zumbador(zumbador),
      .Led_Alarma(led_alarma), .Estado_Act(estado_act)
   );

   always #5 clk = ~clk;

   // Reference model: modes plus absolute tick deadlines.
   // fan: 0 off, 1 on, 2 hold; alarm: 0 idle, 1 beep on, 2 beep off, 3 silenced
   int m_pc, m_ticks, m_fan, m_fdl, m_alm, m_adl;

   task automatic model_edge(input logic r, input logic v, input logic a, input logic s);
      bit t;
      int tn;
      if (r) begin
         m_pc = 0; m_ticks = 0; m_fan = 0; m_alm = 0; m_fdl = 0; m_adl = 0;
      end else begin
         t = (m_pc == TICK_DIV - 1);
         m_pc = (m_pc + 1) % TICK_DIV;
         tn = m_ticks + (t ? 1 : 0);
         case (m_fan)
            0: if (v) begin m_fan = 1; m_fdl = tn + FAN_MIN_ON; end
            1: if (m_ticks >= m_fdl && !v) begin m_fan = 2; m_fdl = tn + FAN_OFF_DLY; end
            default: begin
               if (v) begin m_fan = 1; m_fdl = tn + FAN_MIN_ON; end
               else if (t && tn == m_fdl) m_fan = 0;
            end
         endcase
         if (!a) m_alm = 0;
         else case (m_alm)
            0: begin m_alm = 1; m_adl = tn + BEEP_ON; end
            1: if (s) m_alm = 3;
               else if (t && tn == m_adl) begin m_alm = 2; m_adl = tn + BEEP_OFF; end
            2: if (s) m_alm = 3;
               else if (t && tn == m_adl) begin m_alm = 1; m_adl = tn + BEEP_ON; end
            default: m_alm = 3;
         endcase
         m_ticks = tn;
      end
   endtask

   function automatic logic [6:0] model_vec();
      logic [1:0] f, al;
      f  = 2'(m_fan);
      al = 2'(m_alm);
      return {m_fan != 0, m_alm == 1, m_alm != 0, f, al};
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got {ven,zum,led,est}=%b required %b", name, $time, act, exp);
      end
   endtask

   task automatic chk1(input string name, input bit cond);
      n_checks++;
      if (!cond) begin
         n_err++;
         $display("FAIL %s @%0t: ven=%b zum=%b led=%b est=%b", name, $time,
                  ventilador, zumbador, led_alarma, estado_act);
      end
   endtask

   function automatic logic [6:0] dut_vec();
      return {ventilador, zumbador, led_alarma, estado_act};
   endfunction

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic step(input logic r, input logic v, input logic a, input logic s);
      rst = r; ventilacion = v; alarma = a; silenciar = s;
      @(posedge clk);
      model_edge(r, v, a, s);
      #1;
      chk("model", dut_vec(), model_vec());
   endtask

   typedef struct {
      logic       r, v, a, s;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[9];

   task automatic measure_fan(input string name);
      int d;
      bit done;
      d = 1;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         step(0, 0, 0, 0);
         if (ventilador) d++;
         else done = 1;
      end
      chk1({name, "_dropped"}, done);
      n_checks++;
      if (d < 17 || d > 20) begin
         n_err++;
         $display("FAIL %s: fan high %0d cycles, required 17..20", name, d);
      end
   endtask

   initial begin
      int hi, k;
      bit found;
      logic v, a;
      // {rst, Ventilacion, Alarma, Silenciar} -> {Ventilador, Zumbador, Led, Estado}
      tbl[0] = '{1, 1, 1, 0, 7'b000_0000};
      tbl[1] = '{1, 1, 1, 0, 7'b000_0000};
      tbl[2] = '{1, 1, 1, 0, 7'b000_0000};
      tbl[3] = '{0, 1, 1, 0, 7'b111_0101};
      tbl[4] = '{0, 0, 1, 1, 7'b101_0111};
      tbl[5] = '{0, 0, 0, 0, 7'b100_0100};
      tbl[6] = '{0, 0, 1, 0, 7'b111_0101};
      tbl[7] = '{0, 0, 0, 1, 7'b100_0100};
      tbl[8] = '{1, 0, 0, 0, 7'b000_0000};
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].s);
         chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
      end

      // Single-cycle fan request at every prescaler phase.
      for (int ph = 0; ph < 4; ph++) begin
         step(1, 0, 0, 0);
         for (int j = 0; j < ph; j++) step(0, 0, 0, 0);
         step(0, 1, 0, 0);
         chk1("fan_assert_next", ventilador == 1'b1);
         measure_fan($sformatf("fan_pulse_ph%0d", ph));
      end

      // Re-request during run-on: fan stays on, min-on restarts.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, 0, 0, 0);
         chk1("fan_no_drop_before_hold", ventilador == 1'b1);
         if (estado_act[3:2] == 2'b10) found = 1;
      end
      chk1("fan_hold_reached", found);
      step(0, 1, 0, 0);
      chk1("fan_rerequest", ventilador == 1'b1 && estado_act[3:2] == 2'b01);
      measure_fan("fan_restart");

      // Alarm held: buzzer 2 ticks on, 1 tick off, lamp steady.
      step(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 0);
         chk1("led_steady", led_alarma == 1'b1);
      end
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, 0);
         if (zumbador) hi++;
      end
      n_checks++;
      if (hi != 8) begin
         n_err++;
         $display("FAIL beep_duty: buzzer high %0d of 12 cycles, required 8", hi);
      end

      // Silence during the on phase, then release and re-raise.
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (zumbador) found = 1;
         else step(0, 0, 1, 0);
      end
      chk1("beep_on_reached", found);
      step(0, 0, 1, 1);
      chk1("silence_now", zumbador == 1'b0 && estado_act[1:0] == 2'b11 && led_alarma);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0);
         chk1("silence_hold", zumbador == 1'b0 && led_alarma == 1'b1);
      end
      step(0, 0, 0, 0);
      chk1("silence_release", led_alarma == 1'b0 && estado_act[1:0] == 2'b00);
      step(0, 0, 1, 0);
      chk1("rearm_beep", zumbador == 1'b1 && estado_act[1:0] == 2'b01);

      // Random run against the model; step() does the comparisons.
      v = 0; a = 0; k = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) v = ~v;
         if ($urandom_range(0, 39) == 0) a = ~a;
         step($urandom_range(0, 299) == 0, v, a, $urandom_range(0, 24) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
